// File: rtl/meteor_pkg.sv
// meteor_pkg: game state/mode encodings, base meteor speeds and spawn interval helper
package meteor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_e;
  typedef enum logic [1:0] {SLOW = 2'd0, NORMAL = 2'd1, FAST = 2'd2, NORMAL_ALT = 2'd3} mode_e;
  localparam logic [7:0] SPEED_SLOW = 8'd1;
  localparam logic [7:0] SPEED_NORMAL = 8'd3;
  localparam logic [7:0] SPEED_FAST = 8'd7;
  function automatic logic [7:0] base_speed(input logic [1:0] m);
    return m == SLOW ? SPEED_SLOW : m == FAST ? SPEED_FAST : SPEED_NORMAL;
  endfunction
  function automatic logic [7:0] spawn_interval(input logic [3:0] lvl, input int base, input int floor_v);
    int v;
    v = base - 4 * int'(lvl);
    return 8'(v < floor_v ? floor_v : v);
  endfunction
endpackage

// File: rtl/spawn_timer.sv
// spawn_timer: frame countdown with valid/ready spawn handshake (ports: i_clk, reset_n-style reset, tick, enable, clear, interval, spawn_ready -> spawn_valid)
module spawn_timer #(
  parameter int BASE_INTERVAL = 60
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] interval,
  input  logic       spawn_ready,
  output logic       spawn_valid
);
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  always_comb begin
    valid_d = clear ? 1'b0 : valid_q ? !spawn_ready : cnt_q == 8'd0;
    cnt_d = clear ? 8'(BASE_INTERVAL)
          : (valid_q && spawn_ready) ? interval
          : (tick && enable && !valid_q && cnt_q != 8'd0) ? cnt_q - 8'd1
          : cnt_q;
  end
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      cnt_q   <= 8'(BASE_INTERVAL);
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign spawn_valid = valid_q;
endmodule

// File: rtl/difficulty_scheduler.sv
// difficulty_scheduler: game FSM, frame/level counters and meteor speed register driving spawn_timer
module difficulty_scheduler
  import meteor_pkg::*;
#(
  parameter int FRAMES_PER_LEVEL = 600,
  parameter int MAX_LEVEL        = 15,
  parameter int BASE_INTERVAL    = 60,
  parameter int MIN_INTERVAL     = 8
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       start,
  input  logic       pause,
  input  logic       frame,
  input  logic       collision,
  input  logic [1:0] mode,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [7:0] meteor_speed,
  output logic [3:0] level,
  output logic [1:0] state,
  output logic       game_over
);
  localparam int FW = $clog2(FRAMES_PER_LEVEL + 1);
  state_e          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [3:0]      lvl_q, lvl_d;
  logic [7:0]      spd_q, spd_d;
  logic [7:0]      intv;
  logic            clr, adv, wrap;
  always_comb begin
    state_d = restart ? IDLE
            : (state_q == IDLE && start) ? PLAY
            : (state_q == PLAY && collision) ? OVER
            : (state_q == PLAY && pause) ? PAUSE
            : (state_q == PAUSE && !pause) ? PLAY
            : state_q;
    clr = state_d == IDLE || state_d == OVER;
    adv = frame && state_q == PLAY;
    wrap = fcnt_q == FW'(FRAMES_PER_LEVEL - 1);
    fcnt_d = state_d == IDLE ? '0 : adv ? (wrap ? '0 : fcnt_q + 1'b1) : fcnt_q;
    lvl_d = state_d == IDLE ? 4'd0 : (adv && wrap && lvl_q != 4'(MAX_LEVEL)) ? lvl_q + 4'd1 : lvl_q;
    spd_d = (!clr && (state_q == PLAY || state_q == PAUSE)) ? base_speed(mode) + {4'd0, lvl_q} : 8'd0;
    intv = spawn_interval(lvl_q, BASE_INTERVAL, MIN_INTERVAL);
  end
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      lvl_q   <= 4'd0;
      spd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      lvl_q   <= lvl_d;
      spd_q   <= spd_d;
    end
  end
  spawn_timer #(.BASE_INTERVAL(BASE_INTERVAL)) u_timer (
    .i_clk       (i_clk),
    .reset       (reset),
    .tick        (frame),
    .enable      (state_q == PLAY),
    .clear       (clr),
    .interval    (intv),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid)
  );
  assign state        = state_q;
  assign level        = lvl_q;
  assign meteor_speed = spd_q;
  assign game_over    = state_q == OVER;
endmodule
